// File: rtl/ct_spsram_param_init_pkg.sv
// Shared definitions for the parametrised single-port SRAM wrapper:
// FSM state encoding and the sweep counter width helper.
package ct_spsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // The sweep counter walks every entry once, so it needs one bit per address bit.
    function automatic int cnt_width(input int addr_width);
        return (addr_width < 1) ? 1 : addr_width;
    endfunction

endpackage

// File: rtl/ct_spsram_param_init_if.sv
// Port bundle between cache control logic (master) and the SRAM wrapper (slave).
interface ct_spsram_param_init_if
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 84
) ();

    // Request/response contract: there is no ready signal. A request is taken at
    // every rising edge where cen=0 and init_busy=0 (gwen=0 write, gwen=1 read);
    // requests seen while init_busy=1 are dropped. q_vld is the valid flag of the
    // response and is high for exactly one cycle per accepted read, in order.
    logic [ADDR_WIDTH-1:0] a;
    logic                  cen;
    logic                  gwen;
    logic [DATA_WIDTH-1:0] wen;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_vld;
    logic                  init_busy;
    state_t                state;

    modport master (
        output a, cen, gwen, wen, d,
        input  q, q_vld, init_busy, state
    );

    modport slave (
        input  a, cen, gwen, wen, d,
        output q, q_vld, init_busy, state
    );

endinterface

// File: rtl/ct_spsram_param_array.sv
// Plain DEPTH x DATA_WIDTH synchronous single-port array with active-low
// CEN/GWEN/bit-WEN; 1-cycle read, Q holds when no read is performed.
module ct_spsram_param_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 84
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic                  cen,
    input  logic                  gwen,
    input  logic [DATA_WIDTH-1:0] wen,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Storage is never reset; bits with wen=1 keep their old value.
    always_ff @(posedge clk) begin
        if (!cen && !gwen) begin
            mem[a] <= (mem[a] & wen) | (d & ~wen);
        end
    end

    // Only the output latch is reset so Q is defined before any read.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!cen && gwen) begin
            q <= mem[a];
        end
    end

endmodule

// File: rtl/ct_spsram_param_init.sv
// SRAM wrapper: post-reset clear sweep, request muxing, optional output
// register and read-valid tracking around ct_spsram_param_array.
module ct_spsram_param_init
    import ct_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 84,
    parameter bit                    OUT_REG    = 1'b0,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    ct_spsram_param_init_if.slave  bus
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] LAST = '1;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0] arr_a;
    logic                  arr_cen, arr_gwen;
    logic [DATA_WIDTH-1:0] arr_wen, arr_d, arr_q;
    logic                  rd_issue, rd_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_EN ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        arr_a    = bus.a;
        arr_cen  = 1'b1;
        arr_gwen = 1'b1;
        arr_wen  = '1;
        arr_d    = bus.d;
        rd_issue = 1'b0;
        case (state)
            ST_INIT: begin
                // The sweep owns the port: one full-word write per cycle.
                arr_a    = cnt;
                arr_cen  = 1'b0;
                arr_gwen = 1'b0;
                arr_wen  = '0;
                arr_d    = INIT_VALUE;
                cnt_nx   = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                arr_cen  = bus.cen;
                arr_gwen = bus.gwen;
                arr_wen  = bus.wen;
                rd_issue = !bus.cen && bus.gwen;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
        // Nothing reaches the array on a reset edge.
        if (rst) begin
            arr_cen  = 1'b1;
            rd_issue = 1'b0;
        end
    end

    ct_spsram_param_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .a    (arr_a),
        .cen  (arr_cen),
        .gwen (arr_gwen),
        .wen  (arr_wen),
        .d    (arr_d),
        .q    (arr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1 <= 1'b0;
        end else begin
            rd_s1 <= rd_issue;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_reg;
            logic                  rd_s2;

            // Reset drops a read that is between the array and this stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                    rd_s2 <= 1'b0;
                end else begin
                    rd_s2 <= rd_s1;
                    if (rd_s1) begin
                        q_reg <= arr_q;
                    end
                end
            end

            assign bus.q     = q_reg;
            assign bus.q_vld = rd_s2;
        end else begin : g_out_direct
            assign bus.q     = arr_q;
            assign bus.q_vld = rd_s1;
        end
    endgenerate

    assign bus.init_busy = INIT_EN && ((state == ST_INIT) || rst);
    assign bus.state     = state;

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Bench for ct_spsram_param_init: three instances (default, OUT_REG=1, INIT_EN=0)
// share one request stream; a latency-aware scoreboard checks every read result.
module tb_ct_spsram_param_init;
    import ct_spsram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 84;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] HI   = {{42{1'b1}}, {42{1'b0}}};
    localparam logic [DW-1:0] P5   = 84'h123456789ABCDEF012345;
    localparam logic [DW-1:0] PAT  = 84'hC0FFEE0123456789ABCDE;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    logic [AW-1:0] a = '0;
    logic cen = 1'b1;
    logic gwen = 1'b1;
    logic [DW-1:0] wen = '1;
    logic [DW-1:0] d = '0;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    logic [DW-1:0] model [0:(1 << AW) - 1];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int due_q0[$];
    int due_q1[$];

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] a;
        logic [DW-1:0] wen;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [12];

    ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    ct_spsram_param_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus0.a = a;  assign bus0.cen = cen;  assign bus0.gwen = gwen;
    assign bus0.wen = wen;  assign bus0.d = d;
    assign bus1.a = a;  assign bus1.cen = cen;  assign bus1.gwen = gwen;
    assign bus1.wen = wen;  assign bus1.d = d;
    assign bus2.a = a;  assign bus2.cen = cen;  assign bus2.gwen = gwen;
    assign bus2.wen = wen;  assign bus2.d = d;

    ct_spsram_param_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0), .INIT_EN(1'b1))
        dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    ct_spsram_param_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b1), .INIT_EN(1'b1))
        dut1 (.clk(clk), .rst(rst0), .bus(bus1));
    ct_spsram_param_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0), .INIT_EN(1'b0))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic void push_exp(input logic [DW-1:0] e, input bit both);
        exp_q0.push_back(e);
        due_q0.push_back(cyc + 1);
        if (both) begin
            exp_q1.push_back(e);
            due_q1.push_back(cyc + 2);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc_drive(input logic c, input logic g, input logic [AW-1:0] av,
                             input logic [DW-1:0] w, input logic [DW-1:0] dv);
        cen = c;  gwen = g;  a = av;  wen = w;  d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b1, 1'b1, '0, ONES, '0);
    endtask

    task automatic wr(input logic [AW-1:0] av, input logic [DW-1:0] w, input logic [DW-1:0] dv);
        model[av] = (model[av] & w) | (dv & ~w);
        cyc_drive(1'b0, 1'b0, av, w, dv);
    endtask

    task automatic rd(input logic [AW-1:0] av);
        push_exp(model[av], 1'b1);
        cyc_drive(1'b0, 1'b1, av, ONES, '0);
    endtask

    task automatic do_reset(input bit r0, input bit r2);
        rst0 = r0;  rst2 = r2;  cen = 1'b1;
        @(negedge clk);
        if (r0) check("busy0_in_rst", {83'b0, bus0.init_busy}, 84'd1);
        if (r2) check("busy2_in_rst", {83'b0, bus2.init_busy}, 84'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;  rst2 = 1'b0;
    endtask

    // Random requests every cycle while dut0 sweeps; counts busy cycles.
    task automatic wait_sweep(input int limit, input int start, output int n);
        n = start;
        forever begin
            a = AW'($urandom_range(0, 255));
            cen = 1'($urandom_range(0, 1));
            gwen = 1'($urandom_range(0, 1));
            wen = rand_word();
            d = rand_word();
            @(negedge clk);
            if (bus0.init_busy !== 1'b1) break;
            n++;
            check("sweep_q0", bus0.q, '0);
            check("sweep_q1", bus1.q, '0);
            if (n >= limit) break;
        end
        cen = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (started) begin
            if (due_q0.size() != 0 && due_q0[0] < cyc) begin
                tests++;  fails++;
                $display("FAIL sb0_missing: got no Q_VLD at cycle %0d expected %h", due_q0[0], exp_q0[0]);
                void'(due_q0.pop_front());  void'(exp_q0.pop_front());
            end
            if (bus0.q_vld !== 1'b0) begin
                tests++;
                if (exp_q0.size() == 0) begin
                    fails++;
                    $display("FAIL sb0_unexpected_vld: got q_vld=%b q=%h expected q_vld=0 at cycle %0d", bus0.q_vld, bus0.q, cyc);
                end else begin
                    if (due_q0[0] != cyc || bus0.q !== exp_q0[0]) begin
                        fails++;
                        $display("FAIL sb0_read: got q=%h at cycle %0d expected %h at cycle %0d", bus0.q, cyc, exp_q0[0], due_q0[0]);
                    end
                    void'(due_q0.pop_front());  void'(exp_q0.pop_front());
                end
            end
            if (due_q1.size() != 0 && due_q1[0] < cyc) begin
                tests++;  fails++;
                $display("FAIL sb1_missing: got no Q_VLD at cycle %0d expected %h", due_q1[0], exp_q1[0]);
                void'(due_q1.pop_front());  void'(exp_q1.pop_front());
            end
            if (bus1.q_vld !== 1'b0) begin
                tests++;
                if (exp_q1.size() == 0) begin
                    fails++;
                    $display("FAIL sb1_unexpected_vld: got q_vld=%b q=%h expected q_vld=0 at cycle %0d", bus1.q_vld, bus1.q, cyc);
                end else begin
                    if (due_q1[0] != cyc || bus1.q !== exp_q1[0]) begin
                        fails++;
                        $display("FAIL sb1_read: got q=%h at cycle %0d expected %h at cycle %0d", bus1.q, cyc, exp_q1[0], due_q1[0]);
                    end
                    void'(due_q1.pop_front());  void'(exp_q1.pop_front());
                end
            end
            check("busy2_never", {83'b0, bus2.init_busy}, 84'd0);
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;

        vecs[0]  = '{1'b0, 8'h3C, '0,             ONES,    '0};
        vecs[1]  = '{1'b0, 8'h3C, HI,             '0,      '0};
        vecs[2]  = '{1'b1, 8'h3C, ONES,           '0,      HI};
        vecs[3]  = '{1'b0, 8'h05, '0,             P5,      '0};
        vecs[4]  = '{1'b1, 8'h05, ONES,           '0,      P5};
        vecs[5]  = '{1'b0, 8'h05, ONES,           '0,      '0};
        vecs[6]  = '{1'b1, 8'h05, ONES,           '0,      P5};
        vecs[7]  = '{1'b0, 8'h07, '0,             84'h5A,  '0};
        vecs[8]  = '{1'b1, 8'h07, ONES,           '0,      84'h5A};
        vecs[9]  = '{1'b0, 8'h3C, ~84'hFF,        84'hA5,  '0};
        vecs[10] = '{1'b1, 8'h3C, ONES,           '0,      HI | 84'hA5};
        vecs[11] = '{1'b1, 8'h00, ONES,           '0,      '0};

        // Reset and first sweep
        do_reset(1'b1, 1'b1);
        started = 1'b1;
        @(negedge clk);
        check("rst_q0", bus0.q, '0);
        check("rst_q1", bus1.q, '0);
        check("rst_q2", bus2.q, '0);
        check("rst_vld2", {83'b0, bus2.q_vld}, 84'd0);
        check("rst_busy0", {83'b0, bus0.init_busy}, 84'd1);
        wait_sweep(400, 1, n);
        check_int("sweep_len_first", n, 256);
        check("ready_state0", {83'b0, bus0.state}, {83'b0, ST_READY});
        check("ready_state1", {83'b0, bus1.state}, {83'b0, ST_READY});
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 256; i++) rd(AW'(i));
        idle(3);

        // Table-driven writes/reads
        foreach (vecs[i]) begin
            if (vecs[i].is_rd) begin
                push_exp(vecs[i].exp, 1'b1);
                cyc_drive(1'b0, 1'b1, vecs[i].a, ONES, '0);
            end else begin
                wr(vecs[i].a, vecs[i].wen, vecs[i].d);
            end
        end
        idle(3);

        // Hold: Q keeps the last read value across idles and writes
        rd(8'h07);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_q0", bus0.q, 84'h5A);
            check("hold_q1", bus1.q, 84'h5A);
            idle(1);
        end
        wr(8'h09, '0, 84'hFF);
        idle(2);
        @(negedge clk);
        check("hold_wr_q0", bus0.q, 84'h5A);
        check("hold_wr_q1", bus1.q, 84'h5A);
        idle(1);

        // 16 back-to-back reads of random masked writes
        for (int i = 0; i < 16; i++) wr(AW'(8'h80 + i), rand_word(), rand_word());
        for (int i = 0; i < 16; i++) rd(AW'(8'h80 + i));
        idle(3);

        // INIT_EN=0 instance usable in its first cycle after reset
        do_reset(1'b0, 1'b1);
        wr(8'h00, '0, PAT);
        rd(8'h00);
        @(negedge clk);
        check("ie0_q", bus2.q, PAT);
        check("ie0_vld", {83'b0, bus2.q_vld}, 84'd1);
        check("ie0_state", {83'b0, bus2.state}, {83'b0, ST_READY});
        idle(3);

        // Garbage, in-flight read dropped by reset in the OUT_REG instance
        for (int i = 0; i < 4; i++) wr(AW'(8'h20 + i), '0, rand_word());
        push_exp(model[8'h20], 1'b0);
        cyc_drive(1'b0, 1'b1, 8'h20, ONES, '0);
        do_reset(1'b1, 1'b0);
        wait_sweep(100, 0, n);
        @(posedge clk);
        #1;
        do_reset(1'b1, 1'b0);
        wait_sweep(400, 0, n);
        check_int("sweep_len_restart", n, 256);
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 256; i++) rd(AW'(i));
        idle(4);

        check_int("sb0_drained", exp_q0.size(), 0);
        check_int("sb1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
